layer_output_collector: RTL and testbench



---
 rtl/mlp_pkg.sv | 36 +++
 rtl/pe_capture_bank.sv | 64 ++++++
 rtl/layer_output_collector.sv | 164 ++++++++++++++++
 tb/tb_layer_output_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mlp_pkg
// Description : Shared types and helpers for the MLP layer output path.
//               - state_t : collector FSM states (COLLECT / STREAM / DRAIN)
//               - QW      : quantized PE output width for the default N = 16
//               - rescale : zero-extend a quantized value, then left shift it
// Revision    : 1.0 - initial release
// ============================================================================
package mlp_pkg;

    // Default PE datapath width and the matching quantized width.
    localparam int PE_N  = 16;
    localparam int QW    = PE_N / 2;

    // Widest datapath rescale() supports. Callers widen their operand to this
    // width and cast the result back down to their own N.
    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        STREAM  = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // The caller zero-extends q before the call. Bits shifted above the
    // caller's N are dropped when the caller casts the result to N bits.
    function automatic logic [MAX_W-1:0] rescale(
        input logic [MAX_W-1:0] q,
        input int unsigned      shift
    );
        return q << shift;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_capture_bank.sv
`default_nettype none
// ============================================================================
// Module      : pe_capture_bank
// Description : One N/2-bit capture register and one mask bit per PE.
//               A slot loads once, when its PE reports done while capture is
//               enabled. It then holds its value until the bank is re-armed.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               pe_outp       - packed PE outputs, PE i at [i*(N/2) +: N/2]
//               pe_done       - per-PE done levels
//               capture_en    - capture allowed this cycle
//               arm_clear     - clear the whole mask (buffer contents kept)
//               rd_idx        - read port index
//               rd_data       - captured value of slot rd_idx
//               mask_full     - every slot has captured
// Revision    : 1.0 - initial release
// ============================================================================
module pe_capture_bank
    import mlp_pkg::*;
#(
    parameter int N   = 16,
    parameter int NPE = 4,
    parameter int IW  = $clog2(NPE)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPE*(N/2)-1:0]   pe_outp,
    input  logic [NPE-1:0]         pe_done,
    input  logic                   capture_en,
    input  logic                   arm_clear,
    input  logic [IW-1:0]          rd_idx,
    output logic [N/2-1:0]         rd_data,
    output logic                   mask_full
);

    localparam int c_QW = N / 2;

    logic [c_QW-1:0] w_slot [NPE];
    logic [NPE-1:0]  w_mask;

    for (genvar i = 0; i < NPE; i++) begin : g_slot
        logic [c_QW-1:0] r_q;
        logic            r_m;

        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
                r_m <= 1'b0;
            end else if (arm_clear) begin
                r_m <= 1'b0;
            end else if (capture_en && pe_done[i] && !r_m) begin
                r_q <= pe_outp[i*c_QW +: c_QW];
                r_m <= 1'b1;
            end
        end

        assign w_slot[i] = r_q;
        assign w_mask[i] = r_m;
    end

    assign rd_data   = w_slot[rd_idx];
    assign mask_full = &w_mask;

endmodule
`default_nettype wire

// File: rtl/layer_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : layer_output_collector
// Description : Collects the quantized outputs of one row of PEs. Rescales
//               each value to an N-bit activation and streams the values in
//               PE-index order over valid/ready, REPEAT times. Pulses
//               layer_done after the final word, then waits for every PE to
//               drop done before it re-arms.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               pe_outp       - packed PE outputs (NPE x N/2)
//               pe_done       - per-PE done levels
//               out_data      - activation word
//               out_valid     - out_data valid
//               out_ready     - downstream accepts this cycle
//               out_last      - final word of the final pass
//               layer_done    - one-cycle pulse after the final handshake
//               busy          - high while streaming or draining
// Revision    : 1.0 - initial release
// ============================================================================
module layer_output_collector
    import mlp_pkg::*;
#(
    parameter int N      = 16,
    parameter int NPE    = 4,
    parameter int QSHIFT = 4,
    parameter int REPEAT = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NPE*(N/2)-1:0]   pe_outp,
    input  logic [NPE-1:0]         pe_done,
    output logic [N-1:0]           out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   layer_done,
    output logic                   busy
);

    localparam int c_QW = N / 2;
    localparam int c_IW = $clog2(NPE);
    localparam int c_PW = (REPEAT > 1) ? $clog2(REPEAT) : 1;

    localparam logic [c_IW-1:0] c_LAST_IDX  = c_IW'(NPE - 1);
    localparam logic [c_PW-1:0] c_LAST_PASS = c_PW'(REPEAT - 1);

    if (QSHIFT > N / 2) begin : g_bad_qshift
        $error("layer_output_collector: QSHIFT must be in 0..N/2");
    end
    if (NPE < 2) begin : g_bad_npe
        $error("layer_output_collector: NPE must be >= 2");
    end
    if (REPEAT < 1) begin : g_bad_repeat
        $error("layer_output_collector: REPEAT must be >= 1");
    end

    state_t          r_state;
    state_t          w_state_next;
    logic [c_IW-1:0] r_idx;
    logic [c_PW-1:0] r_pass;
    logic            r_layer_done;

    logic            w_capture_en;
    logic            w_arm_clear;
    logic            w_valid;
    logic            w_last;
    logic            w_fire;
    logic            w_mask_full;
    logic [c_QW-1:0] w_rd;

    pe_capture_bank #(
        .N   (N),
        .NPE (NPE),
        .IW  (c_IW)
    ) u_bank (
        .clk        (clk),
        .rst        (rst),
        .pe_outp    (pe_outp),
        .pe_done    (pe_done),
        .capture_en (w_capture_en),
        .arm_clear  (w_arm_clear),
        .rd_idx     (r_idx),
        .rd_data    (w_rd),
        .mask_full  (w_mask_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_capture_en = 1'b0;
        w_arm_clear  = 1'b0;
        w_valid      = 1'b0;
        case (r_state)
            COLLECT: begin
                w_capture_en = 1'b1;
                if (w_mask_full) begin
                    w_state_next = STREAM;
                end
            end
            STREAM: begin
                w_valid = 1'b1;
                if (out_ready && w_last) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Leave only after every done level has dropped. Otherwise a
                // PE that still holds done from this layer would immediately
                // recapture stale data.
                if (pe_done == '0) begin
                    w_arm_clear  = 1'b1;
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    assign w_last = (r_state == STREAM) && (r_idx == c_LAST_IDX) &&
                    (r_pass == c_LAST_PASS);
    assign w_fire = w_valid && out_ready;

    // Both counters return to zero after the final handshake. They are
    // therefore already at zero when the next COLLECT->STREAM transition
    // happens, and they never step past their limits.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx        <= '0;
            r_pass       <= '0;
            r_layer_done <= 1'b0;
        end else begin
            r_layer_done <= w_fire && w_last;
            if (w_fire) begin
                if (r_idx == c_LAST_IDX) begin
                    r_idx <= '0;
                    if (r_pass == c_LAST_PASS) begin
                        r_pass <= '0;
                    end else begin
                        r_pass <= r_pass + 1'b1;
                    end
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign out_valid  = w_valid;
    assign out_last   = w_last;
    assign out_data   = w_valid ? N'(rescale(MAX_W'(w_rd), 32'(QSHIFT))) : '0;
    assign layer_done = r_layer_done;
    assign busy       = (r_state != COLLECT);

endmodule
`default_nettype wire

// File: tb/tb_layer_output_collector.sv
`default_nettype none
// ============================================================================
// Module      : tb_layer_output_collector
// Description : Directed bench for layer_output_collector. One instance uses
//               REPEAT=1 and a second uses REPEAT=2. Every expected word is
//               written out by hand in the tables below.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layer_output_collector;

    logic        clk;
    logic        rst;
    logic [31:0] pe_outp;
    logic [3:0]  pe_done;
    logic        out_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_last;
    logic        layer_done;
    logic        busy;

    logic [3:0]  pe_done2;
    logic        out_ready2;
    logic [15:0] out_data2;
    logic        out_valid2;
    logic        out_last2;
    logic        layer_done2;
    logic        busy2;

    int n_tests = 0;
    int n_fail  = 0;

    layer_output_collector #(.N(16), .NPE(4), .QSHIFT(4), .REPEAT(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .pe_outp    (pe_outp),
        .pe_done    (pe_done),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_last   (out_last),
        .layer_done (layer_done),
        .busy       (busy)
    );

    layer_output_collector #(.N(16), .NPE(4), .QSHIFT(4), .REPEAT(2)) dut_r2 (
        .clk        (clk),
        .rst        (rst),
        .pe_outp    (pe_outp),
        .pe_done    (pe_done2),
        .out_data   (out_data2),
        .out_valid  (out_valid2),
        .out_ready  (out_ready2),
        .out_last   (out_last2),
        .layer_done (layer_done2),
        .busy       (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are examined 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Runs from the moment word 0 is visible through the layer_done pulse on
    // instance dut. The stall is applied on word index stall_idx.
    task automatic stream4(input string tag, input logic [15:0] e [4],
                           input int stall_idx, input int stall_len);
        for (int w = 0; w < 4; w++) begin
            if (w == stall_idx) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check($sformatf("%s_stall_valid", tag), {31'd0, out_valid}, 32'd1);
                    check($sformatf("%s_stall_data", tag), {16'd0, out_data}, {16'd0, e[w]});
                    tick();
                end
                out_ready = 1'b1;
            end
            check($sformatf("%s_valid%0d", tag, w), {31'd0, out_valid}, 32'd1);
            check($sformatf("%s_data%0d", tag, w), {16'd0, out_data}, {16'd0, e[w]});
            check($sformatf("%s_last%0d", tag, w), {31'd0, out_last}, (w == 3) ? 32'd1 : 32'd0);
            tick();
        end
        check($sformatf("%s_valid_drop", tag), {31'd0, out_valid}, 32'd0);
        check($sformatf("%s_done_pulse", tag), {31'd0, layer_done}, 32'd1);
        check($sformatf("%s_busy_drain", tag), {31'd0, busy}, 32'd1);
        tick();
        check($sformatf("%s_done_single", tag), {31'd0, layer_done}, 32'd0);
    endtask

    logic [15:0] exp_a [4];
    logic [15:0] exp_b [4];
    logic [15:0] exp_c [4];

    initial begin
        exp_a = '{16'h0010, 16'h0020, 16'h07F0, 16'h0FF0};   // 01,02,7F,FF
        exp_b = '{16'h0100, 16'h0200, 16'h0300, 16'h0400};   // 10,20,30,40
        exp_c = '{16'h0800, 16'h0000, 16'h05A0, 16'h0A50};   // 80,00,5A,A5

        rst        = 1'b1;
        pe_outp    = '0;
        pe_done    = '0;
        pe_done2   = '0;
        out_ready  = 1'b1;
        out_ready2 = 1'b1;
        tick();
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_last",  {31'd0, out_last}, 32'd0);
        check("rst_done",  {31'd0, layer_done}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_data",  {16'd0, out_data}, 32'd0);
        rst = 1'b0;

        // In-order capture. PE0's slice changes after it captures; the
        // captured value must stay 0x01.
        pe_outp = 32'hFF7F_0201;
        pe_done = 4'b0001;
        tick();
        pe_outp = 32'hFF7F_02EE;
        check("ord_no_out0", {31'd0, out_valid}, 32'd0);
        pe_done = 4'b0011; tick();
        pe_done = 4'b0111; tick();
        check("ord_busy_collect", {31'd0, busy}, 32'd0);
        pe_done = 4'b1111; tick();
        check("ord_not_yet", {31'd0, out_valid}, 32'd0);
        tick();
        stream4("ord", exp_a, -1, 0);

        // Re-arm: dones held high keep the block draining with no output.
        for (int k = 0; k < 3; k++) begin
            check("drain_busy",  {31'd0, busy}, 32'd1);
            check("drain_valid", {31'd0, out_valid}, 32'd0);
            tick();
        end
        pe_done = 4'b0000;
        tick();
        check("rearm_busy", {31'd0, busy}, 32'd0);

        // Simultaneous done carrying new data: first word two edges later.
        pe_outp = 32'h4030_2010;
        pe_done = 4'b1111;
        tick();
        check("sim_edge1", {31'd0, out_valid}, 32'd0);
        tick();
        stream4("sim", exp_b, -1, 0);
        pe_done = 4'b0000;
        tick();

        // Backpressure on word 2 for three cycles.
        pe_outp = 32'hFF7F_0201;
        pe_done = 4'b1111;
        tick();
        tick();
        stream4("bp", exp_a, 2, 3);
        pe_done = 4'b0000;
        tick();

        // Mid-stream reset while word 1 is pending.
        pe_outp = 32'hA55A_0080;
        pe_done = 4'b1111;
        tick();
        tick();
        check("mrst_w0", {16'd0, out_data}, {16'd0, exp_c[0]});
        tick();
        check("mrst_w1", {16'd0, out_data}, {16'd0, exp_c[1]});
        rst = 1'b1;
        tick();
        check("mrst_valid", {31'd0, out_valid}, 32'd0);
        check("mrst_busy",  {31'd0, busy}, 32'd0);
        rst = 1'b0;
        tick();
        check("mrst_recap", {31'd0, out_valid}, 32'd0);
        tick();
        stream4("mrst", exp_c, -1, 0);
        pe_done = 4'b0000;
        tick();

        // REPEAT=2 instance: eight words, the sequence twice, one pulse.
        pe_outp  = 32'hFF7F_0201;
        pe_done2 = 4'b1111;
        tick();
        tick();
        for (int w = 0; w < 8; w++) begin
            check($sformatf("r2_valid%0d", w), {31'd0, out_valid2}, 32'd1);
            check($sformatf("r2_data%0d", w), {16'd0, out_data2}, {16'd0, exp_a[w % 4]});
            check($sformatf("r2_last%0d", w), {31'd0, out_last2}, (w == 7) ? 32'd1 : 32'd0);
            check($sformatf("r2_nodone%0d", w), {31'd0, layer_done2}, 32'd0);
            tick();
        end
        check("r2_valid_drop", {31'd0, out_valid2}, 32'd0);
        check("r2_done_pulse", {31'd0, layer_done2}, 32'd1);
        tick();
        check("r2_done_single", {31'd0, layer_done2}, 32'd0);
        check("r2_busy_drain",  {31'd0, busy2}, 32'd1);
        pe_done2 = 4'b0000;
        tick();
        check("r2_rearm", {31'd0, busy2}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
